// File: rtl/key_event_fifo_pkg.sv
// Shared key-code definitions for the keypad path (key_event_fifo, password_lock).
// Optional feature macro used by key_event_fifo: KEY_EVENT_SERIALIZE_EN.
package key_event_pkg;

    localparam int KEY_NUM    = 16;
    localparam int KEY_CODE_W = 4;

    typedef logic [KEY_CODE_W-1:0] key_code_t;

    localparam key_code_t KEY_CODE_0   = 4'h0;
    localparam key_code_t KEY_CODE_1   = 4'h1;
    localparam key_code_t KEY_CODE_2   = 4'h2;
    localparam key_code_t KEY_CODE_3   = 4'h3;
    localparam key_code_t KEY_CODE_4   = 4'h4;
    localparam key_code_t KEY_CODE_5   = 4'h5;
    localparam key_code_t KEY_CODE_6   = 4'h6;
    localparam key_code_t KEY_CODE_7   = 4'h7;
    localparam key_code_t KEY_CODE_8   = 4'h8;
    localparam key_code_t KEY_CODE_9   = 4'h9;
    localparam key_code_t KEY_CODE_CLR = 4'hC;
    localparam key_code_t KEY_CODE_ENT = 4'hF;

endpackage

// File: rtl/key_event_fifo_encoder.sv
// Lowest-set-bit priority encoder for the key_trigger vector.
// 'any' flags a non-zero vector, 'multi' flags two or more set bits.
module key_onehot_encoder
    import key_event_pkg::*;
#(
    parameter int N = KEY_NUM
) (
    input  logic [N-1:0] vec,
    output key_code_t    code,
    output logic         any,
    output logic         multi
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        code = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                code = KEY_CODE_W'(i);
            end
        end
        any   = |vec;
        multi = (vec & (vec - N'(1))) != '0;
    end

endmodule

// File: rtl/key_event_fifo.sv
// Keypad event FIFO: encodes key_trigger pulses into 4-bit codes and queues
// them in a first-word-fall-through FIFO with a valid/ready consumer port.
// Optional macro KEY_EVENT_SERIALIZE_EN: multi-key vectors are held in a
// pending register and pushed one code per cycle instead of being dropped.
module key_event_fifo #(
    parameter int KEY_NUM = 16,
    parameter int DEPTH   = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [KEY_NUM-1:0] key_trigger,
    input  logic               clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [3:0]         evt_code,
    output logic [CNT_W-1:0]   evt_count,
    output logic               full,
    output logic               overflow,
    output logic               multi_drop
);

    import key_event_pkg::*;

    localparam int AW = $clog2(DEPTH);

    key_code_t          mem [DEPTH];
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   wr_next;
    logic [CNT_W-1:0]   rd_next;
    logic [CNT_W-1:0]   count_next;
    logic [KEY_NUM-1:0] enc_in;
    key_code_t          enc_code;
    logic               enc_any;
    logic               enc_multi;
    logic               do_pop;
    logic               do_push;

`ifdef KEY_EVENT_SERIALIZE_EN
    logic [KEY_NUM-1:0] pend_q;
    logic [KEY_NUM-1:0] pend_next;

    assign enc_in     = pend_q | key_trigger;
    assign multi_drop = 1'b0;
`else
    assign enc_in = key_trigger;
`endif

    key_onehot_encoder #(
        .N(KEY_NUM)
    ) u_encoder (
        .vec  (enc_in),
        .code (enc_code),
        .any  (enc_any),
        .multi(enc_multi)
    );

    // Handshake decisions and next pointer values; a full FIFO still accepts a push when it pops
    always_comb begin
        do_pop     = evt_valid && evt_ready;
        do_push    = enc_any && (!full || do_pop);
        wr_next    = wr_ptr + CNT_W'(do_push);
        rd_next    = rd_ptr + CNT_W'(do_pop);
        count_next = wr_next - rd_next;
`ifdef KEY_EVENT_SERIALIZE_EN
        pend_next  = do_push ? (enc_in & (enc_in - KEY_NUM'(1))) : enc_in;
`endif
    end

    // Pointer, status and sticky-flag registers; clr outranks push and pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_count  <= '0;
            evt_valid  <= 1'b0;
            full       <= 1'b0;
            overflow   <= 1'b0;
`ifdef KEY_EVENT_SERIALIZE_EN
            pend_q     <= '0;
`else
            multi_drop <= 1'b0;
`endif
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_count  <= '0;
            evt_valid  <= 1'b0;
            full       <= 1'b0;
            overflow   <= 1'b0;
`ifdef KEY_EVENT_SERIALIZE_EN
            pend_q     <= '0;
`else
            multi_drop <= 1'b0;
`endif
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            evt_count <= count_next;
            evt_valid <= count_next != '0;
            full      <= count_next == CNT_W'(DEPTH);
`ifdef KEY_EVENT_SERIALIZE_EN
            pend_q    <= pend_next;
            if ((pend_q != '0) && ((key_trigger & pend_q) != '0)) begin
                overflow <= 1'b1;
            end
`else
            if (enc_any && full && !do_pop) begin
                overflow <= 1'b1;
            end
            if (enc_multi) begin
                multi_drop <= 1'b1;
            end
`endif
        end
    end

    // Storage array, written at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr[AW-1:0]] <= enc_code;
        end
    end

    assign evt_code = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
Buffers keypad events between matrix_key_trigger and password_lock. Consumes the 16-bit one-cycle key_trigger pulse vector. Encodes each press into a 4-bit key code and queues it in a small FWFT FIFO. Presents codes to the consumer over a valid/ready handshake, so no press is lost while the consumer is busy (e.g. blinking the display or comparing the password).

Parameters:
KEY_NUM, 16, width of key_trigger; codes are 0..KEY_NUM-1.
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
CNT_W, $clog2(DEPTH)+1, occupancy width (localparam, derived).

Ports:
clk  input  1  system clock (external_clk domain)
rstn  input  1  asynchronous active-low reset
key_trigger  input  KEY_NUM  one-cycle pulse per key press, from matrix_key_trigger
clr  input  1  synchronous flush of FIFO and sticky flags
evt_valid  output  1  head entry available
evt_ready  input  1  consumer accepts head entry this cycle
evt_code  output  4  key code of head entry (index of pressed key)
evt_count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  evt_count == DEPTH
overflow  output  1  sticky: a press was discarded because the FIFO was full
multi_drop  output  1  sticky: more than one key_trigger bit was set in one cycle

Behaviour:
- Reset (rstn low, async): evt_valid=0, evt_code=0, evt_count=0, full=0, overflow=0, multi_drop=0. Read/write pointers go to 0. Memory contents are don't-care.
- Push request: the cycle in which key_trigger != 0.
- Encoding: the lowest set bit index wins. If two or more bits are set, push only the lowest index and set multi_drop.
- Pop: the cycle in which evt_valid && evt_ready. Asserting evt_ready while evt_valid=0 has no effect.
- FWFT: evt_code is valid whenever evt_valid=1 and is held stable until the entry is popped.
- Latency: a press in cycle N into an empty FIFO gives evt_valid=1 with its code in cycle N+1. No same-cycle bypass.
- Pointers: CNT_W-bit read and write pointers; the low bits address the memory. Wrap-around is natural binary rollover. evt_count = wr_ptr - rd_ptr, registered.
- Full, push only: the press is discarded, overflow is set, and count is unchanged.
- Full, push and pop in the same cycle: both are accepted, and count stays at DEPTH.
- Empty, push and pop: pop is ignored (evt_valid=0), and the push is accepted.
- Neither full nor empty, push and pop: both are accepted, and count is unchanged.
- clr has priority over push and pop in the same cycle. It zeroes the pointers, count, overflow and multi_drop. evt_valid=0 from the next cycle.
- The sticky flags clear only on reset or clr.
- Reset mid-operation clears everything immediately. Queued presses are lost by design.
- full and evt_valid are registered, with no combinational path from evt_ready.

Optional Feature:
KEY_EVENT_SERIALIZE_EN
- Defined: a multi-bit key_trigger vector is latched into a pending register. One code is pushed per cycle, lowest index first, until the register drains. multi_drop is never set and is tied 0.
- New triggers arriving while the register is non-empty are OR-merged into it. A key already pending is not pushed twice.
- Bits that cannot be pushed because the FIFO is full remain pending; they are neither dropped nor flagged as overflow. overflow is set only if the pending register is non-zero and a new trigger bit collides with an already-pending bit.
- Undefined: behaviour is exactly as in Behaviour (lowest bit wins, multi_drop).

Decomposition:
- Package key_event_pkg holds:
  - KEY_NUM and KEY_CODE_W=4;
  - named key code constants: KEY_CODE_0..KEY_CODE_9 = 0..9, KEY_CODE_CLR = 4'hC, KEY_CODE_ENT = 4'hF; these are shared with password_lock;
  - a typedef key_code_t = logic [3:0].
- Sub-module key_onehot_encoder: combinational lowest-set-bit priority encoder. Outputs code, any, and multi. It is reused by the serializer path.

Test Plan:
- Reset, then pulse key_trigger=16'h0020 for one cycle with evt_ready=0 -> next cycle evt_valid=1, evt_code=5, evt_count=1.
- Push codes 1..9 with evt_ready=0 (DEPTH=8) -> full=1 after the 8th push, the 9th press is discarded, overflow=1, and a drain yields 1..8 in order.
- key_trigger=16'h8081 in one cycle -> a single entry with code 0, multi_drop=1, evt_count=1. With KEY_EVENT_SERIALIZE_EN: codes 0, 7, 15 on three consecutive pushes and multi_drop=0.
- Fill to full, then in one cycle pulse key_trigger=16'h0004 with evt_ready=1 -> head popped, code 2 appended at the tail, evt_count stays 8, overflow stays 0.
- Push 20 presses with evt_ready held 1, one press per cycle -> pointers wrap, output order matches input, evt_count never exceeds 1.
- With 3 entries queued, pulse clr together with a press -> next cycle evt_valid=0, evt_count=0, flags 0, and the press is not stored.
